// File: rtl/pulse_gen_multi_if.sv
// Control/status bundle for pulse_gen_multi: per-channel fields are packed
// side by side, with channel i at slice [i*W +: W].
interface pulse_gen_multi_if #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
);
    logic [NCH*CNT_W-1:0]   high_len;
    logic [NCH*CNT_W-1:0]   low_len;
    logic [NCH*2-1:0]       mode;
    logic [NCH*BURST_W-1:0] burst_num;
    logic [NCH-1:0]         start;
    logic [NCH-1:0]         stop;
    logic [NCH-1:0]         pulse_out;
    logic [NCH-1:0]         busy;
    logic [NCH-1:0]         rise;
    logic [NCH-1:0]         done;

    modport master (
        output high_len, low_len, mode, burst_num, start, stop,
        input  pulse_out, busy, rise, done
    );

    modport slave (
        input  high_len, low_len, mode, burst_num, start, stop,
        output pulse_out, busy, rise, done
    );
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse timer: each channel independently runs free-run,
// one-shot or burst pulses with per-phase lengths latched at phase entry.
module pulse_gen_multi #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    pulse_gen_multi_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_FREE  = 2'd0;
    localparam logic [1:0] MODE_ONE   = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    logic [NCH-1:0] pulse_vec;
    logic [NCH-1:0] busy_vec;
    logic [NCH-1:0] rise_vec;
    logic [NCH-1:0] done_vec;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            state_e             state_q, state_d;
            logic [CNT_W-1:0]   cnt_q, cnt_d;
            logic [CNT_W-1:0]   len_q, len_d;
            logic [1:0]         mode_q, mode_d;
            logic [BURST_W-1:0] remain_q, remain_d;
            logic               rise_q, rise_d;
            logic               done_q, done_d;

            logic [CNT_W-1:0]   high_len_ch;
            logic [CNT_W-1:0]   low_len_ch;
            logic [1:0]         mode_ch;
            logic [BURST_W-1:0] burst_ch;
            logic               start_ch;
            logic               stop_ch;
            logic               phase_end;

            assign high_len_ch = bus.high_len[gi*CNT_W +: CNT_W];
            assign low_len_ch  = bus.low_len[gi*CNT_W +: CNT_W];
            assign mode_ch     = bus.mode[gi*2 +: 2];
            assign burst_ch    = bus.burst_num[gi*BURST_W +: BURST_W];
            assign start_ch    = bus.start[gi];
            assign stop_ch     = bus.stop[gi];

            // len_q holds the length of whichever phase is currently running.
            assign phase_end = (cnt_q == len_q);

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    len_q    <= '0;
                    mode_q   <= '0;
                    remain_q <= '0;
                    rise_q   <= 1'b0;
                    done_q   <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    len_q    <= len_d;
                    mode_q   <= mode_d;
                    remain_q <= remain_d;
                    rise_q   <= rise_d;
                    done_q   <= done_d;
                end
            end

            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                len_d    = len_q;
                mode_d   = mode_q;
                remain_d = remain_q;
                rise_d   = 1'b0;
                done_d   = 1'b0;

                // Abort wins over launch and over phase completion.
                if (stop_ch) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (start_ch && (mode_ch != MODE_RSVD)) begin
                                state_d  = ST_HIGH;
                                cnt_d    = '0;
                                len_d    = high_len_ch;
                                mode_d   = mode_ch;
                                remain_d = (burst_ch == '0) ? BURST_W'(1) : burst_ch;
                                rise_d   = 1'b1;
                            end
                        end

                        ST_HIGH: begin
                            if (!phase_end) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end else begin
                                cnt_d = '0;
                                case (mode_q)
                                    MODE_FREE: begin
                                        state_d = ST_LOW;
                                        len_d   = low_len_ch;
                                    end
                                    MODE_BURST: begin
                                        remain_d = remain_q - BURST_W'(1);
                                        // Final pulse of a burst ends without a trailing gap.
                                        if (remain_q == BURST_W'(1)) begin
                                            state_d = ST_IDLE;
                                            done_d  = 1'b1;
                                        end else begin
                                            state_d = ST_LOW;
                                            len_d   = low_len_ch;
                                        end
                                    end
                                    default: begin
                                        state_d = ST_IDLE;
                                        done_d  = 1'b1;
                                    end
                                endcase
                            end
                        end

                        ST_LOW: begin
                            if (phase_end) begin
                                state_d = ST_HIGH;
                                cnt_d   = '0;
                                len_d   = high_len_ch;
                                rise_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end

                        default: begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            assign pulse_vec[gi] = (state_q == ST_HIGH);
            assign busy_vec[gi]  = (state_q == ST_HIGH) || (state_q == ST_LOW);
            assign rise_vec[gi]  = rise_q;
            assign done_vec[gi]  = done_q;
        end
    endgenerate

    assign bus.pulse_out = pulse_vec;
    assign bus.busy      = busy_vec;
    assign bus.rise      = rise_vec;
    assign bus.done      = done_vec;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: free-run, one-shot, burst, stop,
// mid-phase length change, reset and reserved-mode behaviour.
module tb_pulse_gen_multi;
    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int BW  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pulse_gen_multi_if #(.NCH(NCH), .CNT_W(CW), .BURST_W(BW)) bus ();

    pulse_gen_multi #(.NCH(NCH), .CNT_W(CW), .BURST_W(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input logic [1:0] m, input logic [CW-1:0] h,
                       input logic [CW-1:0] l, input logic [BW-1:0] n);
        bus.mode[ch*2 +: 2]       = m;
        bus.high_len[ch*CW +: CW] = h;
        bus.low_len[ch*CW +: CW]  = l;
        bus.burst_num[ch*BW +: BW] = n;
    endtask

    int p5 [11] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
    int rises;

    initial begin
        reset = 1'b1;
        bus.start = '0;
        bus.stop = '0;
        bus.mode = '0;
        bus.high_len = '0;
        bus.low_len = '0;
        bus.burst_num = '0;
        step();
        step();
        chk("rst_pulse", 32'(bus.pulse_out), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rise", 32'(bus.rise), 0);
        chk("rst_done", 32'(bus.done), 0);
        reset = 1'b0;
        step();
        chk("idle_busy", 32'(bus.busy), 0);
        $display("reset: outputs idle");

        // Free-run on ch0: 3 high / 2 low.
        cfg(0, 2'd0, 2, 1, 0);
        bus.start[0] = 1'b1;
        step();
        bus.start[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            chk($sformatf("t1_pulse[%0d]", i), 32'(bus.pulse_out[0]), 32'((i % 5) < 3));
            chk($sformatf("t1_rise[%0d]", i), 32'(bus.rise[0]), 32'((i % 5) == 0));
            chk($sformatf("t1_busy[%0d]", i), 32'(bus.busy[0]), 1);
            chk($sformatf("t1_done[%0d]", i), 32'(bus.done[0]), 0);
        end
        $display("ch0 free-run H=2 L=1: 10 cycles checked");

        // Stop during a high phase, then stop+start together while idle.
        step();
        chk("t4_high_before_stop", 32'(bus.pulse_out[0]), 1);
        bus.stop[0] = 1'b1;
        step();
        bus.stop[0] = 1'b0;
        chk("t4_stop_pulse", 32'(bus.pulse_out[0]), 0);
        chk("t4_stop_busy", 32'(bus.busy[0]), 0);
        chk("t4_stop_done", 32'(bus.done[0]), 0);
        chk("t4_stop_rise", 32'(bus.rise[0]), 0);
        step();
        chk("t4_stays_idle", 32'(bus.busy[0]), 0);
        bus.stop[0] = 1'b1;
        bus.start[0] = 1'b1;
        step();
        bus.stop[0] = 1'b0;
        bus.start[0] = 1'b0;
        chk("t4_ss_busy", 32'(bus.busy[0]), 0);
        chk("t4_ss_pulse", 32'(bus.pulse_out[0]), 0);
        chk("t4_ss_rise", 32'(bus.rise[0]), 0);
        step();
        chk("t4_ss_idle", 32'(bus.busy[0]), 0);
        $display("ch0 stop: aborted with no done, stop beats start");

        // One-shot on ch1, H=4; start held on the done edge must be ignored.
        cfg(1, 2'd1, 4, 0, 0);
        bus.start[1] = 1'b1;
        step();
        bus.start[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk($sformatf("t2_pulse[%0d]", i), 32'(bus.pulse_out[1]), 1);
            chk($sformatf("t2_busy[%0d]", i), 32'(bus.busy[1]), 1);
            chk($sformatf("t2_rise[%0d]", i), 32'(bus.rise[1]), 32'(i == 0));
            chk($sformatf("t2_done[%0d]", i), 32'(bus.done[1]), 0);
        end
        bus.start[1] = 1'b1;
        step();
        bus.start[1] = 1'b0;
        chk("t2_end_pulse", 32'(bus.pulse_out[1]), 0);
        chk("t2_end_done", 32'(bus.done[1]), 1);
        chk("t2_end_busy", 32'(bus.busy[1]), 0);
        chk("t2_end_rise", 32'(bus.rise[1]), 0);
        step();
        chk("t2_after_done", 32'(bus.done[1]), 0);
        chk("t2_no_relaunch", 32'(bus.busy[1]), 0);
        $display("ch1 one-shot H=4: 5-cycle pulse then done");

        // Burst on ch2: 3 pulses, H=0, L=2.
        cfg(2, 2'd2, 0, 2, 3);
        bus.start[2] = 1'b1;
        step();
        bus.start[2] = 1'b0;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            chk($sformatf("t3_pulse[%0d]", i), 32'(bus.pulse_out[2]), 32'((i < 9) && ((i % 4) == 0)));
            chk($sformatf("t3_rise[%0d]", i), 32'(bus.rise[2]), 32'((i < 9) && ((i % 4) == 0)));
            chk($sformatf("t3_done[%0d]", i), 32'(bus.done[2]), 32'(i == 9));
            chk($sformatf("t3_busy[%0d]", i), 32'(bus.busy[2]), 32'(i < 9));
            rises += int'(bus.rise[2]);
        end
        chk("t3_rise_count", 32'(rises), 3);
        step();
        chk("t3_done_once", 32'(bus.done[2]), 0);
        $display("ch2 burst n=3: three pulses then done");

        // burst_num=0 behaves as a single pulse.
        cfg(2, 2'd2, 1, 0, 0);
        bus.start[2] = 1'b1;
        step();
        bus.start[2] = 1'b0;
        chk("t3z_pulse0", 32'(bus.pulse_out[2]), 1);
        step();
        chk("t3z_pulse1", 32'(bus.pulse_out[2]), 1);
        step();
        chk("t3z_pulse2", 32'(bus.pulse_out[2]), 0);
        chk("t3z_done", 32'(bus.done[2]), 1);
        chk("t3z_busy", 32'(bus.busy[2]), 0);
        $display("ch2 burst n=0: single pulse");

        // Free-run on ch3: high_len 2->5 mid phase only affects the next high.
        cfg(3, 2'd0, 2, 0, 0);
        bus.start[3] = 1'b1;
        step();
        bus.start[3] = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            chk($sformatf("t5_pulse[%0d]", i), 32'(bus.pulse_out[3]), 32'(p5[i]));
            chk($sformatf("t5_rise[%0d]", i), 32'(bus.rise[3]), 32'((i == 0) || (i == 4)));
            if (i == 1) bus.high_len[3*CW +: CW] = 5;
        end
        $display("ch3 free-run: high_len change took effect next phase");

        // All channels running, then a one-cycle reset with start held.
        cfg(0, 2'd0, 3, 3, 0);
        cfg(1, 2'd0, 1, 2, 0);
        cfg(2, 2'd0, 0, 0, 0);
        bus.start[2:0] = 3'b111;
        step();
        bus.start = '0;
        step();
        step();
        chk("t6_all_busy", 32'(bus.busy), 32'hF);
        reset = 1'b1;
        bus.start = 4'hF;
        step();
        reset = 1'b0;
        bus.start = '0;
        chk("t6_rst_pulse", 32'(bus.pulse_out), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_rise", 32'(bus.rise), 0);
        chk("t6_rst_done", 32'(bus.done), 0);
        step();
        chk("t6_post_busy", 32'(bus.busy), 0);
        $display("reset mid-run: all channels idle");

        // Reserved mode: start does nothing.
        cfg(0, 2'd3, 1, 1, 1);
        bus.start[0] = 1'b1;
        step();
        chk("t6_rsvd_busy", 32'(bus.busy[0]), 0);
        chk("t6_rsvd_pulse", 32'(bus.pulse_out[0]), 0);
        chk("t6_rsvd_rise", 32'(bus.rise[0]), 0);
        step();
        bus.start[0] = 1'b0;
        chk("t6_rsvd_busy2", 32'(bus.busy[0]), 0);
        $display("ch0 mode 3: start ignored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
